// File: rtl/stg_pkg.sv
// Stage-wide constants shared by the enemy controllers:
// play-field size, coordinate width and boss phase codes.
package stg_pkg;

  localparam int COORD_W = 10;
  localparam int MAX_X   = 384;
  localparam int MAX_Y   = 448;

  typedef logic [COORD_W-1:0] coord_t;

  localparam logic [2:0] PH_ENTER  = 3'd0;
  localparam logic [2:0] PH_HOVER  = 3'd1;
  localparam logic [2:0] PH_ATTACK = 3'd2;
  localparam logic [2:0] PH_MOVE   = 3'd3;
  localparam logic [2:0] PH_DEAD   = 3'd4;

endpackage

// File: rtl/step_ticker.sv
// Free-running step divider with hold enable; emits a
// one-cycle tick on the cycle the count wraps.
module step_ticker #(
  parameter int unsigned DIV = 5000000,
  parameter int unsigned W   = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  output logic tick_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         wrap;

  assign wrap   = (cnt_q == W'(DIV - 1));
  assign tick_o = en_i & wrap;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i)
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/boss_pattern_sequencer.sv
// Boss controller: entry/hover/attack/move sequencing,
// HP tracking and fire req/ack handshake to the spawner.
module boss_pattern_sequencer
  import stg_pkg::*;
#(
  parameter int unsigned STEP_DIV    = 5000000,
  parameter int unsigned X_HOME      = 192,
  parameter int unsigned Y_START     = 0,
  parameter int unsigned Y_HOME      = 100,
  parameter int unsigned X_MIN       = 64,
  parameter int unsigned X_MAX       = 320,
  parameter int unsigned HOVER_STEPS = 40,
  parameter int unsigned BURST_LEN   = 4,
  parameter int unsigned SHOT_GAP    = 8,
  parameter int unsigned HP_INIT     = 200
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               freeze,
  input  logic               hit,
  input  logic               fire_ack,
  output logic [COORD_W-1:0] boss_x,
  output logic [COORD_W-1:0] boss_y,
  output logic               boss_active,
  output logic [7:0]         hp,
  output logic [2:0]         phase,
  output logic               fire_req,
  output logic [1:0]         fire_pattern,
  output logic               boss_dead
);

  localparam coord_t XHOME = coord_t'(X_HOME);
  localparam coord_t YSTRT = coord_t'(Y_START);
  localparam coord_t YHOME = coord_t'(Y_HOME);
  localparam coord_t XMIN  = coord_t'(X_MIN);
  localparam coord_t XMAX  = coord_t'(X_MAX);

  coord_t      x_q, x_d, y_q, y_d, x_nx;
  logic [7:0]  hp_q, hp_d, burst_q, burst_d;
  logic [2:0]  ph_q, ph_d;
  logic [15:0] wait_q, wait_d, gap_q, gap_d;
  logic [1:0]  pat_q, pat_d;
  logic        req_q, req_d, dead_q, dead_d;
  logic        act_q, act_d, dir_q, dir_d;
  logic        tick, alive;

  step_ticker #(.DIV(STEP_DIV), .W(26)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .en_i   (~freeze),
    .tick_o (tick)
  );

  assign alive = (ph_q == PH_HOVER) | (ph_q == PH_ATTACK)
               | (ph_q == PH_MOVE);

  always_comb begin
    if (dir_q) x_nx = (x_q >= XMAX) ? XMAX : x_q + 1'b1;
    else       x_nx = (x_q <= XMIN) ? XMIN : x_q - 1'b1;
  end

  always_comb begin
    x_d = x_q; y_d = y_q; hp_d = hp_q; ph_d = ph_q;
    wait_d = wait_q; gap_d = gap_q; burst_d = burst_q;
    pat_d = pat_q; req_d = req_q; dead_d = dead_q;
    act_d = act_q; dir_d = dir_q;
    if (!freeze) begin
      unique case (ph_q)
        PH_ENTER: if (tick) begin
          y_d = y_q + 1'b1;
          if (y_q + 1'b1 == YHOME) begin
            ph_d   = PH_HOVER;
            wait_d = '0;
          end
        end
        PH_HOVER: if (tick) begin
          if (wait_q == 16'(HOVER_STEPS - 1)) begin
            ph_d    = PH_ATTACK;
            burst_d = '0;
            gap_d   = '0;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
        PH_ATTACK: begin
          if (req_q) begin
            if (fire_ack) begin
              req_d   = 1'b0;
              burst_d = burst_q + 1'b1;
              gap_d   = 16'(SHOT_GAP);
              if (burst_q + 1'b1 == 8'(BURST_LEN))
                ph_d = PH_MOVE;
            end
          end else if (gap_q != '0) begin
            if (tick) gap_d = gap_q - 1'b1;
          end else begin
            req_d = 1'b1;
            pat_d = burst_q[1:0];
          end
        end
        PH_MOVE: if (tick) begin
          x_d = x_nx;
          if ((dir_q && x_nx == XMAX) || (!dir_q && x_nx == XMIN)) begin
            dir_d  = ~dir_q;
            ph_d   = PH_HOVER;
            wait_d = '0;
          end
        end
        default: ;
      endcase
      // A kill overrides any movement or shot accounting this cycle
      if (alive && hit) begin
        hp_d = (hp_q == 8'd0) ? 8'd0 : hp_q - 8'd1;
        if (hp_q <= 8'd1) begin
          ph_d    = PH_DEAD;
          req_d   = 1'b0;
          dead_d  = 1'b1;
          act_d   = 1'b0;
          burst_d = burst_q;
          x_d     = x_q;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q     <= XHOME;
      y_q     <= YSTRT;
      hp_q    <= 8'(HP_INIT);
      ph_q    <= PH_ENTER;
      wait_q  <= '0;
      gap_q   <= '0;
      burst_q <= '0;
      pat_q   <= '0;
      req_q   <= 1'b0;
      dead_q  <= 1'b0;
      act_q   <= 1'b1;
      dir_q   <= 1'b1;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      hp_q    <= hp_d;
      ph_q    <= ph_d;
      wait_q  <= wait_d;
      gap_q   <= gap_d;
      burst_q <= burst_d;
      pat_q   <= pat_d;
      req_q   <= req_d;
      dead_q  <= dead_d;
      act_q   <= act_d;
      dir_q   <= dir_d;
    end
  end

  assign boss_x       = x_q;
  assign boss_y       = y_q;
  assign hp           = hp_q;
  assign phase        = ph_q;
  assign fire_req     = req_q;
  assign fire_pattern = pat_q;
  assign boss_dead    = dead_q;
  assign boss_active  = act_q;

endmodule

// File: tb/tb_boss_pattern_sequencer.sv
// Directed bench for boss_pattern_sequencer: main instance
// (HP 200) plus a low-HP instance for kill and async reset.
module tb_boss_pattern_sequencer;

  logic       clk = 1'b0;
  logic       reset, freeze, hit, fire_ack;
  logic [9:0] boss_x, boss_y;
  logic       boss_active, fire_req, boss_dead;
  logic [7:0] hp;
  logic [2:0] phase;
  logic [1:0] fire_pattern;

  logic       k_reset, k_freeze, k_hit, k_ack;
  logic [9:0] k_x, k_y;
  logic       k_active, k_req, k_dead;
  logic [7:0] k_hp;
  logic [2:0] k_phase;
  logic [1:0] k_pat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  boss_pattern_sequencer #(.STEP_DIV(4)) dut (
    .clk(clk), .reset(reset), .freeze(freeze), .hit(hit),
    .fire_ack(fire_ack), .boss_x(boss_x), .boss_y(boss_y),
    .boss_active(boss_active), .hp(hp), .phase(phase),
    .fire_req(fire_req), .fire_pattern(fire_pattern),
    .boss_dead(boss_dead)
  );

  boss_pattern_sequencer #(.STEP_DIV(4), .HP_INIT(3)) dutk (
    .clk(clk), .reset(k_reset), .freeze(k_freeze), .hit(k_hit),
    .fire_ack(k_ack), .boss_x(k_x), .boss_y(k_y),
    .boss_active(k_active), .hp(k_hp), .phase(k_phase),
    .fire_req(k_req), .fire_pattern(k_pat),
    .boss_dead(k_dead)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; freeze = 1'b0; hit = 1'b0; fire_ack = 1'b0;
    step(); step();
    checks++;
    if ({boss_x, boss_y, hp, phase, fire_req, fire_pattern,
         boss_dead, boss_active} !==
        {10'd192, 10'd0, 8'd200, 3'd0, 1'b0, 2'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: x=%0d y=%0d hp=%0d ph=%0d req=%b pat=%0d dead=%b act=%b, want 192 0 200 0 0 0 0 1",
               boss_x, boss_y, hp, phase, fire_req, fire_pattern,
               boss_dead, boss_active);
    end
  endtask

  task automatic test_entry();
    bit over = 1'b0;
    reset = 1'b0;
    for (int n = 1; n <= 400; n++) begin
      hit = (n >= 10 && n < 13);
      step();
      if (boss_y > 10'd100) over = 1'b1;
      if (n == 3) begin
        checks++;
        if (boss_y !== 10'd0) begin
          errors++;
          $display("FAIL entry_pre_tick: y=%0d want 0", boss_y);
        end
      end
      if (n == 4) begin
        checks++;
        if (boss_y !== 10'd1) begin
          errors++;
          $display("FAIL entry_first_tick: y=%0d want 1", boss_y);
        end
      end
      if (n == 399) begin
        checks++;
        if (boss_y !== 10'd99 || phase !== 3'd0) begin
          errors++;
          $display("FAIL entry_99: y=%0d ph=%0d want 99 0", boss_y, phase);
        end
      end
      if (n == 400) begin
        checks++;
        if (boss_y !== 10'd100 || phase !== 3'd1) begin
          errors++;
          $display("FAIL entry_home: y=%0d ph=%0d want 100 1", boss_y, phase);
        end
      end
    end
    hit = 1'b0;
    checks++;
    if (hp !== 8'd200 || over) begin
      errors++;
      $display("FAIL entry_invuln: hp=%0d over=%b want 200 0", hp, over);
    end
  endtask

  task automatic test_handshake();
    int n = 0;
    bit ok = 1'b1;
    while (phase !== 3'd2 && n < 300) begin step(); n++; end
    checks++;
    if (n != 160) begin
      errors++;
      $display("FAIL hover_len: edges=%0d want 160", n);
    end
    step();
    checks++;
    if (fire_req !== 1'b1 || fire_pattern !== 2'd0) begin
      errors++;
      $display("FAIL first_req: req=%b pat=%0d want 1 0", fire_req, fire_pattern);
    end
    repeat (50) begin
      step();
      if (fire_req !== 1'b1 || fire_pattern !== 2'd0 || phase !== 3'd2) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL req_stable: req=%b pat=%0d want held 1 0", fire_req, fire_pattern);
    end
    fire_ack = 1'b1; step(); fire_ack = 1'b0;
    checks++;
    if (fire_req !== 1'b0 || phase !== 3'd2) begin
      errors++;
      $display("FAIL ack_drop: req=%b ph=%0d want 0 2", fire_req, phase);
    end
    fire_ack = 1'b1; step(); fire_ack = 1'b0;
    n = 1;
    while (fire_req !== 1'b1 && n < 60) begin step(); n++; end
    checks++;
    if (n != 33 || fire_pattern !== 2'd1) begin
      errors++;
      $display("FAIL shot_gap: edges=%0d pat=%0d want 33 1", n, fire_pattern);
    end
    for (int s = 1; s < 4; s++) begin
      n = 0;
      while (fire_req !== 1'b1 && n < 60) begin step(); n++; end
      checks++;
      if (fire_req !== 1'b1 || fire_pattern !== 2'(s)) begin
        errors++;
        $display("FAIL shot_%0d: req=%b pat=%0d want 1 %0d", s, fire_req, fire_pattern, s);
      end
      fire_ack = 1'b1; step(); fire_ack = 1'b0;
    end
    checks++;
    if (fire_req !== 1'b0 || phase !== 3'd3 || boss_x !== 10'd192) begin
      errors++;
      $display("FAIL burst_done: req=%b ph=%0d x=%0d want 0 3 192", fire_req, phase, boss_x);
    end
  endtask

  task automatic run_attack();
    int n = 0;
    while (phase !== 3'd3 && n < 2000) begin
      fire_ack = fire_req; step(); n++;
    end
    fire_ack = 1'b0;
    checks++;
    if (phase !== 3'd3) begin
      errors++;
      $display("FAIL attack_to_move: ph=%0d want 3", phase);
    end
  endtask

  task automatic test_bounds();
    int n = 0;
    bit ok = 1'b1;
    while (phase !== 3'd1 && n < 1000) begin
      step(); n++;
      if (boss_x > 10'd320 || boss_x < 10'd64) ok = 1'b0;
    end
    checks++;
    if (boss_x !== 10'd320 || phase !== 3'd1 || !ok) begin
      errors++;
      $display("FAIL right_bound: x=%0d ph=%0d inb=%b want 320 1 1", boss_x, phase, ok);
    end
    run_attack();
    n = 0;
    while (phase !== 3'd1 && n < 2000) begin
      step(); n++;
      if (boss_x > 10'd320 || boss_x < 10'd64) ok = 1'b0;
    end
    checks++;
    if (boss_x !== 10'd64 || phase !== 3'd1 || !ok) begin
      errors++;
      $display("FAIL left_bound: x=%0d ph=%0d inb=%b want 64 1 1", boss_x, phase, ok);
    end
  endtask

  task automatic test_freeze();
    int n = 0;
    bit ok = 1'b1;
    run_attack();
    while (boss_x !== 10'd100 && n < 1000) begin step(); n++; end
    step(); step();
    freeze = 1'b1;
    for (int i = 0; i < 100; i++) begin
      hit = i[0];
      fire_ack = i[1];
      step();
      if (boss_x !== 10'd100 || hp !== 8'd200 || phase !== 3'd3 ||
          fire_req !== 1'b0) ok = 1'b0;
    end
    freeze = 1'b0; hit = 1'b0; fire_ack = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL freeze_hold: x=%0d hp=%0d ph=%0d req=%b want 100 200 3 0",
               boss_x, hp, phase, fire_req);
    end
    step();
    checks++;
    if (boss_x !== 10'd100) begin
      errors++;
      $display("FAIL freeze_resume_early: x=%0d want 100", boss_x);
    end
    step();
    checks++;
    if (boss_x !== 10'd101) begin
      errors++;
      $display("FAIL freeze_resume: x=%0d want 101", boss_x);
    end
    hit = 1'b1; step(); step(); hit = 1'b0;
    checks++;
    if (hp !== 8'd198 || phase !== 3'd3) begin
      errors++;
      $display("FAIL hp_hits: hp=%0d ph=%0d want 198 3", hp, phase);
    end
  endtask

  task automatic test_async_reset();
    int n = 0;
    k_freeze = 1'b0; k_hit = 1'b0; k_ack = 1'b0;
    k_reset = 1'b1; step(); step(); k_reset = 1'b0;
    while (k_req !== 1'b1 && n < 700) begin step(); n++; end
    checks++;
    if (k_req !== 1'b1 || k_phase !== 3'd2) begin
      errors++;
      $display("FAIL k_reach_attack: req=%b ph=%0d want 1 2", k_req, k_phase);
    end
    k_reset = 1'b1;
    #2;
    checks++;
    if ({k_x, k_y, k_hp, k_phase, k_req, k_pat, k_dead, k_active} !==
        {10'd192, 10'd0, 8'd3, 3'd0, 1'b0, 2'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL async_reset: x=%0d y=%0d hp=%0d ph=%0d req=%b pat=%0d dead=%b act=%b, want 192 0 3 0 0 0 0 1",
               k_x, k_y, k_hp, k_phase, k_req, k_pat, k_dead, k_active);
    end
    step();
    k_reset = 1'b0;
  endtask

  task automatic test_kill();
    int n = 0;
    while (k_req !== 1'b1 && n < 700) begin step(); n++; end
    k_hit = 1'b1; step();
    checks++;
    if (k_hp !== 8'd2 || k_phase !== 3'd2 || k_req !== 1'b1) begin
      errors++;
      $display("FAIL kill_hit1: hp=%0d ph=%0d req=%b want 2 2 1", k_hp, k_phase, k_req);
    end
    step();
    checks++;
    if (k_hp !== 8'd1 || k_phase !== 3'd2) begin
      errors++;
      $display("FAIL kill_hit2: hp=%0d ph=%0d want 1 2", k_hp, k_phase);
    end
    k_ack = 1'b1; step(); k_hit = 1'b0; k_ack = 1'b0;
    checks++;
    if ({k_hp, k_phase, k_dead, k_req, k_active} !==
        {8'd0, 3'd4, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL kill_dead: hp=%0d ph=%0d dead=%b req=%b act=%b want 0 4 1 0 0",
               k_hp, k_phase, k_dead, k_req, k_active);
    end
    step();
    k_ack = 1'b1; k_hit = 1'b1;
    repeat (5) step();
    k_ack = 1'b0; k_hit = 1'b0;
    repeat (20) step();
    checks++;
    if ({k_x, k_y, k_hp, k_phase, k_req, k_pat, k_dead, k_active} !==
        {10'd192, 10'd100, 8'd0, 3'd4, 1'b0, 2'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL dead_sticky: x=%0d y=%0d hp=%0d ph=%0d req=%b pat=%0d dead=%b act=%b, want 192 100 0 4 0 0 1 0",
               k_x, k_y, k_hp, k_phase, k_req, k_pat, k_dead, k_active);
    end
  endtask

  initial begin
    k_reset = 1'b1; k_freeze = 1'b0; k_hit = 1'b0; k_ack = 1'b0;
    test_reset();
    test_entry();
    test_handshake();
    test_bounds();
    test_freeze();
    test_async_reset();
    test_kill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
